// File: rtl/impulse_convolver_pkg.sv
// impulse_convolver_pkg: shared audio types, sample width and saturation helper.
package impulse_convolver_pkg;
  localparam int SAMPLE_W = 16;
  typedef enum logic [2:0] {DISARMED, CLEAR, IDLE, ACCUM, OUTPUT} conv_state_t;
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [47:0] v);
    return v > 48'sd32767 ? 16'sh7fff : v < -48'sd32768 ? 16'sh8000 : v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/impulse_convolver_if.sv
// impulse_convolver_if: audio stream, impulse-memory read port and status signals.
interface impulse_convolver_if;
  import impulse_convolver_pkg::*;
  logic                       audio_trigger;
  logic signed [SAMPLE_W-1:0] audio_in;
  logic                       impulse_ready;
  logic                       impulse_clear;
  logic [15:0]                imp_addr;
  logic signed [SAMPLE_W-1:0] imp_data;
  logic signed [SAMPLE_W-1:0] audio_out;
  logic                       out_valid;
  logic                       busy;
  logic                       overrun;
  modport master (
    output audio_trigger, audio_in, impulse_ready, impulse_clear, imp_data,
    input  imp_addr, audio_out, out_valid, busy, overrun
  );
  modport slave (
    input  audio_trigger, audio_in, impulse_ready, impulse_clear, imp_data,
    output imp_addr, audio_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/impulse_convolver_sample_history.sv
// sample_history: DEPTH x 16 simple dual-port RAM with a two-stage registered read.
module sample_history
  import impulse_convolver_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [AW-1:0]              waddr_i,
  input  logic signed [SAMPLE_W-1:0] wdata_i,
  input  logic [AW-1:0]              raddr_i,
  output logic signed [SAMPLE_W-1:0] rdata_o
);
  logic signed [SAMPLE_W-1:0] mem_q [DEPTH];
  logic signed [SAMPLE_W-1:0] rd1_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rd1_q   <= mem_q[raddr_i];
    rdata_o <= rd1_q;
  end
endmodule

// File: rtl/impulse_convolver.sv
// impulse_convolver: time-multiplexed single-MAC FIR of live audio against the stored impulse.
module impulse_convolver
  import impulse_convolver_pkg::*;
#(
  parameter int TAPS      = 1024,
  parameter int OUT_SHIFT = 15
) (
  input logic               audio_clk,
  input logic               rst_in,
  impulse_convolver_if.slave bus
);
  localparam int KW = $clog2(TAPS);
  localparam int AW = 32 + KW;
  conv_state_t                state_q, state_d;
  logic [KW:0]                k_q, k_d;
  logic [KW-1:0]              head_q, head_d;
  logic [2:0]                 vld_q, lst_q;
  logic signed [31:0]         prod_q;
  logic signed [AW-1:0]       acc_q, acc_d;
  logic signed [SAMPLE_W-1:0] out_q, out_d;
  logic                       out_valid_q, out_valid_d;
  logic                       overrun_q, overrun_d;
  logic                       issue, start, hist_we;
  logic [KW-1:0]              hist_waddr, hist_raddr;
  logic signed [SAMPLE_W-1:0] hist_wdata, hist_rdata;
  // k doubles as the CLEAR sweep address and the ACCUM tap index; its MSB marks issue done
  assign issue      = state_q == ACCUM && !k_q[KW];
  assign start      = state_q == IDLE && bus.audio_trigger;
  assign hist_we    = state_q == CLEAR || start;
  assign hist_waddr = state_q == CLEAR ? k_q[KW-1:0] : head_q;
  assign hist_wdata = state_q == CLEAR ? '0 : bus.audio_in;
  assign hist_raddr = head_q - k_q[KW-1:0];
  assign bus.imp_addr  = issue ? 16'(k_q[KW-1:0]) : '0;
  assign bus.audio_out = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = state_q == CLEAR || state_q == ACCUM;
  assign bus.overrun   = overrun_q;
  sample_history #(.DEPTH(TAPS)) u_hist (
    .clk     (audio_clk),
    .we_i    (hist_we),
    .waddr_i (hist_waddr),
    .wdata_i (hist_wdata),
    .raddr_i (hist_raddr),
    .rdata_o (hist_rdata)
  );
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    head_d      = head_q;
    acc_d       = vld_q[2] ? acc_q + AW'(prod_q) : acc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q | (bus.audio_trigger && state_q inside {CLEAR, ACCUM, OUTPUT});
    case (state_q)
      DISARMED: if (bus.impulse_ready) begin
        state_d = CLEAR;
        k_d     = '0;
      end
      CLEAR: begin
        k_d = k_q + 1'b1;
        if (k_q == (KW+1)'(TAPS-1)) begin
          state_d = IDLE;
          head_d  = '0;
        end
      end
      IDLE: if (bus.audio_trigger) begin
        state_d = ACCUM;
        k_d     = '0;
        acc_d   = '0;
      end
      ACCUM: begin
        k_d     = issue ? k_q + 1'b1 : k_q;
        state_d = vld_q[2] && lst_q[2] ? OUTPUT : ACCUM;
      end
      OUTPUT: begin
        out_d       = sat16(48'(acc_q >>> OUT_SHIFT));
        out_valid_d = 1'b1;
        head_d      = head_q + 1'b1;
        state_d     = IDLE;
      end
      default: state_d = DISARMED;
    endcase
    if (bus.impulse_clear) begin
      state_d     = DISARMED;
      out_d       = '0;
      out_valid_d = 1'b0;
    end
  end
  // issue -> 2-cycle RAM reads -> product register -> accumulate
  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= DISARMED;
      k_q         <= '0;
      head_q      <= '0;
      vld_q       <= '0;
      lst_q       <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      head_q      <= head_d;
      vld_q       <= bus.impulse_clear ? 3'b000 : {vld_q[1:0], issue};
      lst_q       <= {lst_q[1:0], issue && k_q[KW-1:0] == KW'(TAPS-1)};
      prod_q      <= vld_q[1] ? 32'(hist_rdata) * 32'(bus.imp_data) : prod_q;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end
endmodule

// File: tb/tb_impulse_convolver.sv
// tb_impulse_convolver: directed stimulus with a convolution reference model feeding a scoreboard.
module tb_impulse_convolver;
  localparam int TAPS = 16;
  typedef struct {
    logic signed [15:0] y;
    int                 t;
  } exp_t;
  logic audio_clk = 1'b0;
  logic rst_in = 1'b0;
  impulse_convolver_if bus();
  impulse_convolver #(.TAPS(TAPS), .OUT_SHIFT(15)) dut (
    .audio_clk (audio_clk),
    .rst_in    (rst_in),
    .bus       (bus.slave)
  );
  always #5 audio_clk = ~audio_clk;
  logic signed [15:0] h [TAPS];
  logic [15:0]        ra_q;
  logic signed [15:0] rd_q;
  always @(posedge audio_clk) begin
    ra_q <= bus.imp_addr;
    rd_q <= h[ra_q[3:0]];
  end
  assign bus.imp_data = rd_q;
  int cyc = 0;
  always @(posedge audio_clk) cyc <= cyc + 1;
  exp_t   sb[$];
  exp_t   e;
  int     checks = 0, passes = 0, fails = 0, nvalid = 0, head = 0;
  integer xs [TAPS];
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask
  function automatic logic signed [15:0] ref_sat(input longint v);
    return v > 32767 ? 16'sh7fff : v < -32768 ? 16'sh8000 : 16'(v);
  endfunction
  always @(negedge audio_clk) if (bus.out_valid === 1'b1) begin
    nvalid++;
    if (sb.size() == 0) chk("spurious_valid", 1, 0);
    else begin
      e = sb.pop_front();
      chk("audio_out", bus.audio_out, e.y);
      chk("latency", cyc - e.t, TAPS + 5);
    end
  end
  task automatic send(input int x, input bit keep);
    longint acc;
    bus.audio_trigger = 1'b1;
    bus.audio_in = x[15:0];
    if (keep) begin
      xs[head] = x;
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += longint'(h[k]) * longint'(xs[(head - k + TAPS) % TAPS]);
      sb.push_back('{ref_sat(acc >>> 15), cyc});
      head = (head + 1) % TAPS;
    end
    @(negedge audio_clk);
    bus.audio_trigger = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge audio_clk);
    chk("drain", sb.size(), 0);
    @(negedge audio_clk);
  endtask
  task automatic pulse_clear();
    @(negedge audio_clk);
    bus.impulse_clear = 1'b1;
    @(negedge audio_clk);
    bus.impulse_clear = 1'b0;
  endtask
  task automatic arm();
    int n;
    for (int i = 0; i < TAPS; i++) xs[i] = 0;
    head = 0;
    @(negedge audio_clk);
    bus.impulse_ready = 1'b1;
    @(negedge audio_clk);
    bus.impulse_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && bus.busy === 1'b1; i++) begin
      n++;
      @(negedge audio_clk);
    end
    chk("clear_len", n, TAPS);
  endtask
  task automatic set_taps(input logic signed [15:0] all, input logic signed [15:0] h0, input logic signed [15:0] h1, input logic signed [15:0] h3);
    for (int i = 0; i < TAPS; i++) h[i] = all;
    h[0] = h0;
    h[1] = h1;
    h[3] = h3;
  endtask
  initial begin
    int n0;
    bus.audio_trigger = 1'b0;
    bus.audio_in = '0;
    bus.impulse_ready = 1'b0;
    bus.impulse_clear = 1'b0;
    set_taps(16'sd0, 16'sd0, 16'sd0, 16'sd0);
    for (int i = 0; i < TAPS; i++) xs[i] = 0;
    repeat (3) @(negedge audio_clk);
    chk("rst_imp_addr", bus.imp_addr, 0);
    chk("rst_audio_out", bus.audio_out, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    rst_in = 1'b1;
    @(negedge audio_clk);
    send(5555, 1'b0);
    repeat (30) @(negedge audio_clk);
    chk("disarmed_valids", nvalid, 0);
    chk("disarmed_out", bus.audio_out, 0);
    chk("disarmed_overrun", bus.overrun, 0);
    set_taps(16'sd0, 16'sd32767, 16'sd0, 16'sd0);
    arm();
    send(1000, 1'b1);
    drain();
    chk("delta_pos_hold", bus.audio_out, 999);
    send(-2000, 1'b1);
    drain();
    chk("delta_neg_hold", bus.audio_out, -2000);
    pulse_clear();
    set_taps(16'sd0, 16'sd0, 16'sd0, 16'sd16384);
    arm();
    send(4000, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) begin
      send(0, 1'b1);
      drain();
      if (i == 2) chk("delay3_half", bus.audio_out, 2000);
    end
    chk("delay3_last", bus.audio_out, 0);
    pulse_clear();
    set_taps(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
    arm();
    repeat (3) begin
      send(32767, 1'b1);
      drain();
    end
    chk("sat_pos", bus.audio_out, 32767);
    pulse_clear();
    arm();
    repeat (3) begin
      send(-32768, 1'b1);
      drain();
    end
    chk("sat_neg", bus.audio_out, -32768);
    chk("overrun_before", bus.overrun, 0);
    pulse_clear();
    set_taps(16'sd0, 16'sd32767, 16'sd16384, 16'sd0);
    arm();
    n0 = nvalid;
    send(1000, 1'b1);
    repeat (4) @(negedge audio_clk);
    send(7777, 1'b0);
    chk("overrun_set", bus.overrun, 1);
    drain();
    chk("overrun_one_valid", nvalid - n0, 1);
    send(3000, 1'b1);
    drain();
    chk("overrun_history", bus.audio_out, 3499);
    chk("overrun_sticky", bus.overrun, 1);
    send(500, 1'b0);
    repeat (8) @(negedge audio_clk);
    n0 = nvalid;
    pulse_clear();
    repeat (30) @(negedge audio_clk);
    send(600, 1'b0);
    repeat (30) @(negedge audio_clk);
    chk("abandon_valids", nvalid - n0, 0);
    chk("abandon_out", bus.audio_out, 0);
    chk("abandon_busy", bus.busy, 0);
    chk("abandon_overrun", bus.overrun, 1);
    @(negedge audio_clk);
    bus.impulse_ready = 1'b1;
    bus.impulse_clear = 1'b1;
    @(negedge audio_clk);
    bus.impulse_ready = 1'b0;
    bus.impulse_clear = 1'b0;
    chk("clear_wins", bus.busy, 0);
    arm();
    send(2000, 1'b1);
    drain();
    chk("rearm_zero_hist", bus.audio_out, 1999);
    send(100, 1'b0);
    repeat (7) @(negedge audio_clk);
    chk("mid_accum_busy", bus.busy, 1);
    n0 = nvalid;
    rst_in = 1'b0;
    #1;
    chk("arst_imp_addr", bus.imp_addr, 0);
    chk("arst_audio_out", bus.audio_out, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_overrun", bus.overrun, 0);
    @(negedge audio_clk);
    rst_in = 1'b1;
    @(negedge audio_clk);
    send(100, 1'b0);
    repeat (40) @(negedge audio_clk);
    chk("arst_no_valid", nvalid - n0, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
